slow_clk_monitor: RTL and testbench

Receiving end of the divided slow-clock outputs: takes one toggling slow-clock square wave (1 Hz, 5 Hz or 400 Hz domain signal) into the system-clock domain. It synchronizes the wave, emits single-cycle edge strobes for downstream counters and display logic, and measures each period in system-clock cycles. It declares lock once the period matches the expected value. One instance per slow clock; all logic runs on the system clock.

---
 rtl/slow_clk_monitor.sv | 187 ++++++++++++++++++
 tb/tb_slow_clk_monitor.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/slow_clk_monitor.sv
// slow_clk_monitor: brings one slow square wave into the clk domain, emits
// single-cycle edge strobes, measures rise-to-rise period in clk cycles and
// declares lock after LOCK_COUNT consecutive in-range periods.
// Optional feature: define SLOW_CLK_MON_FALL_EN to drive tick_fall and check
// the high time against EXP_PERIOD/2 +/- TOL at every falling edge.
module slow_clk_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 27,
  parameter int unsigned EXP_PERIOD  = 250_002,
  parameter int unsigned TOL         = 16,
  parameter int unsigned LOCK_COUNT  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             slow_in,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             err_pulse
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(EXP_PERIOD - TOL);
  localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W-1:0] T_OUT   = CNT_W'(EXP_PERIOD + TOL + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);
  localparam logic [GOOD_W-1:0] GOOD_ONE  = GOOD_W'(1);

  typedef enum logic [1:0] {
    SEEK   = 2'd0,
    TRAIN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t                 state_q, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s_last;
  logic                   rise_c;
  logic [CNT_W-1:0]       cnt_q, cnt_n;
  logic [CNT_W-1:0]       period_n;
  logic [GOOD_W-1:0]      good_q, good_n;
  logic                   pv_n;
  logic                   err_n;
  logic                   period_ok;
  logic                   timeout_c;
`ifdef SLOW_CLK_MON_FALL_EN
  localparam logic [CNT_W-1:0] H_MIN = CNT_W'(EXP_PERIOD / 2 - TOL);
  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(EXP_PERIOD / 2 + TOL);
  logic fall_c;
  logic high_ok;
  logic fall_q;
`endif

  assign s_last = sync_q[SYNC_STAGES-1];
  assign rise_c = s_last & ~prev_q;
`ifdef SLOW_CLK_MON_FALL_EN
  assign fall_c = ~s_last & prev_q;
`endif

  // Synchronizer chain and edge-detect delay flop
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], slow_in};
      prev_q <= s_last;
    end
  end

  // Range tests on the running counter (cnt equals distance since last rise)
  always_comb begin
    period_ok = (cnt_q >= P_MIN) && (cnt_q <= P_MAX);
    timeout_c = !rise_c && (cnt_q == T_OUT);
`ifdef SLOW_CLK_MON_FALL_EN
    high_ok   = (cnt_q >= H_MIN) && (cnt_q <= H_MAX);
`endif
  end

  // Next-state, counter and strobe logic; a rise always beats a timeout
  always_comb begin
    state_n  = state_q;
    good_n   = good_q;
    period_n = period;
    pv_n     = 1'b0;
    err_n    = 1'b0;

    if (rise_c) begin
      cnt_n = CNT_ONE;
    end else if (state_q == SEEK) begin
      cnt_n = '0;
    end else if (cnt_q != '1) begin
      cnt_n = cnt_q + CNT_ONE;
    end else begin
      cnt_n = cnt_q;
    end

    case (state_q)
      SEEK: begin
        if (rise_c) begin
          state_n = TRAIN;
          good_n  = '0;
        end
      end
      TRAIN, LOCKED: begin
        if (rise_c) begin
          period_n = cnt_q;
          pv_n     = 1'b1;
          if (period_ok) begin
            if (state_q == TRAIN) begin
              if (good_q + GOOD_ONE == GOOD_LOCK) begin
                state_n = LOCKED;
                good_n  = '0;
              end else begin
                good_n = good_q + GOOD_ONE;
              end
            end
          end else begin
            err_n   = 1'b1;
            state_n = TRAIN;
            good_n  = '0;
          end
        end else if (timeout_c) begin
          err_n   = 1'b1;
          state_n = SEEK;
          good_n  = '0;
          cnt_n   = '0;
        end
`ifdef SLOW_CLK_MON_FALL_EN
        else if (fall_c && !high_ok) begin
          err_n   = 1'b1;
          state_n = TRAIN;
          good_n  = '0;
        end
`endif
      end
      default: begin
        state_n = SEEK;
        good_n  = '0;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEEK;
      good_q       <= '0;
      cnt_q        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      err_pulse    <= 1'b0;
      tick_rise    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state_q      <= state_n;
      good_q       <= good_n;
      cnt_q        <= cnt_n;
      period       <= period_n;
      period_valid <= pv_n;
      err_pulse    <= err_n;
      tick_rise    <= rise_c;
      locked       <= (state_q == LOCKED);
    end
  end

`ifdef SLOW_CLK_MON_FALL_EN
  // Falling-edge strobe register
  always_ff @(posedge clk) begin
    if (rst) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= fall_c;
    end
  end

  assign tick_fall = fall_q;
`else
  assign tick_fall = 1'b0;
`endif

endmodule

// File: tb/tb_slow_clk_monitor.sv
// Self-checking bench for slow_clk_monitor (SYNC_STAGES=2, EXP_PERIOD=20,
// TOL=1, LOCK_COUNT=2). Honors SLOW_CLK_MON_FALL_EN in the model.
module tb_slow_clk_monitor;

  localparam int unsigned CNT_W = 8;
  localparam int EXP  = 20;
  localparam int TOLV = 1;
  localparam int LOCK = 2;

  logic             clk;
  logic             rst;
  logic             slow_in;
  logic             tick_rise;
  logic             tick_fall;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             err_pulse;

  int checks   = 0;
  int failures = 0;

  slow_clk_monitor #(
    .SYNC_STAGES(2), .CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(TOLV), .LOCK_COUNT(LOCK)
  ) dut (
    .clk(clk), .rst(rst), .slow_in(slow_in), .tick_rise(tick_rise),
    .tick_fall(tick_fall), .period(period), .period_valid(period_valid),
    .locked(locked), .err_pulse(err_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  // Observed DUT strobe statistics used by literal checks
  int cyc = 0;
  int rise_cnt = 0, fall_cnt = 0, pv_cnt = 0, err_cnt = 0;
  int last_rise_cyc = 0, last_err_cyc = 0, err_pv_period = -1;

  // Behavioural model: events measured as distances in clk edges
  typedef enum int {M_SEEK, M_TRAIN, M_LOCKED} mode_t;
  mode_t mode = M_SEEK;
  logic [3:0] hist = '0;
  int last_m = 0;
  int run = 0;
  int period_m = 0;
  logic e_rise, e_fall, e_pv, e_err, e_locked;

  always begin
    logic smp, rs;
    int d;
    @(posedge clk);
    smp = slow_in;
    rs  = rst;
    cyc++;
    if (rs) begin
      hist = '0; mode = M_SEEK; run = 0; period_m = 0;
      e_rise = 0; e_fall = 0; e_pv = 0; e_err = 0; e_locked = 0;
    end else begin
      // input sampled at edge n appears as a strobe after edge n+2
      hist     = {hist[2:0], smp};
      e_rise   = hist[2] & ~hist[3];
      e_locked = (mode == M_LOCKED);
      e_pv     = 0;
      e_err    = 0;
      e_fall   = 0;
      d = cyc - last_m;
      if (e_rise) begin
        if (mode != M_SEEK) begin
          period_m = d;
          e_pv = 1;
          if (d >= EXP - TOLV && d <= EXP + TOLV) begin
            if (mode == M_TRAIN) begin
              run++;
              if (run == LOCK) mode = M_LOCKED;
            end
          end else begin
            e_err = 1; mode = M_TRAIN; run = 0;
          end
        end else begin
          mode = M_TRAIN; run = 0;
        end
        last_m = cyc;
      end else if (mode != M_SEEK && d == EXP + TOLV + 1) begin
        e_err = 1; mode = M_SEEK; run = 0;
      end
`ifdef SLOW_CLK_MON_FALL_EN
      else if (mode != M_SEEK && (~hist[2] & hist[3]) &&
               (d < EXP / 2 - TOLV || d > EXP / 2 + TOLV)) begin
        e_err = 1; mode = M_TRAIN; run = 0;
      end
      e_fall = ~hist[2] & hist[3];
`endif
    end
    #1;
    chk("tick_rise", int'(tick_rise), int'(e_rise));
    chk("tick_fall", int'(tick_fall), int'(e_fall));
    chk("period_valid", int'(period_valid), int'(e_pv));
    chk("period", int'(period), period_m);
    chk("locked", int'(locked), int'(e_locked));
    chk("err_pulse", int'(err_pulse), int'(e_err));
    if (tick_rise) begin rise_cnt++; last_rise_cyc = cyc; end
    if (tick_fall) fall_cnt++;
    if (period_valid) pv_cnt++;
    if (err_pulse) begin
      err_cnt++;
      last_err_cyc = cyc;
      if (period_valid) err_pv_period = int'(period);
    end
  end

  task automatic drive(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      slow_in = v;
    end
  endtask

  task automatic wave(input int hi, input int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
  endtask

  initial begin
    int r0, f0, p0, e0;
    rst = 1'b1;
    slow_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_locked", int'(locked), 0);
    chk("rst_period", int'(period), 0);

    // Quiet after reset
    r0 = rise_cnt; p0 = pv_cnt; e0 = err_cnt;
    drive(1'b0, 10);
    chk("quiet_strobes", (rise_cnt - r0) + (pv_cnt - p0) + (err_cnt - e0), 0);

    // Clean 10/10 wave: first rise unmeasured, lock after third
    r0 = rise_cnt; p0 = pv_cnt; e0 = err_cnt;
    for (int i = 0; i < 5; i++) wave(10, 10);
    chk("clean_rises", rise_cnt - r0, 5);
    chk("clean_pv", pv_cnt - p0, 4);
    chk("clean_period", int'(period), 20);
    chk("clean_locked", int'(locked), 1);
    chk("clean_err", err_cnt - e0, 0);

    // One 22-cycle period (rise coincides with timeout boundary), then relock
    p0 = pv_cnt; e0 = err_cnt; err_pv_period = -1;
    wave(11, 11);
    for (int i = 0; i < 3; i++) wave(10, 10);
    drive(1'b1, 10);
    chk("bad_err", err_cnt - e0, 1);
    chk("bad_err_period", err_pv_period, 22);
    chk("bad_pv", pv_cnt - p0, 5);
    chk("relock", int'(locked), 1);

    // Timeout from lock: single err 22 cycles after last rise
    p0 = pv_cnt; e0 = err_cnt;
    drive(1'b0, 40);
    chk("to_err", err_cnt - e0, 1);
    chk("to_dist", last_err_cyc - last_rise_cyc, 22);
    chk("to_pv", pv_cnt - p0, 0);
    chk("to_locked", int'(locked), 0);

    // High-time stimulus: 13 high / 7 low inside a locked stream
    e0 = err_cnt; f0 = fall_cnt;
    for (int i = 0; i < 3; i++) wave(10, 10);
    wave(13, 7);
    wave(10, 10);
`ifdef SLOW_CLK_MON_FALL_EN
    chk("ht_err", err_cnt - e0, 1);
    chk("ht_falls", fall_cnt - f0, 5);
`else
    chk("ht_err", err_cnt - e0, 0);
    chk("ht_falls", fall_cnt - f0, 0);
`endif

    // Reset mid-lock, then relock after three rises
    wave(10, 10);
    wave(10, 10);
    chk("pre_rst_locked", int'(locked), 1);
    e0 = err_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_period", int'(period), 0);
    for (int i = 0; i < 3; i++) wave(10, 10);
    chk("mid_rst_err", err_cnt - e0, 0);
    chk("post_rst_locked", int'(locked), 1);

    // Randomized waves, glitches, timeouts and resets against the model
    for (int i = 0; i < 150; i++) begin
      int sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0) begin
        slow_in = 1'($urandom_range(0, 1));
        rst = 1'b1;
        repeat (int'($urandom_range(1, 3))) @(negedge clk);
        rst = 1'b0;
      end else if (sel == 1) begin
        drive(1'b0, 30);
      end else if (sel == 2) begin
        wave(int'($urandom_range(1, 2)), int'($urandom_range(1, 3)));
      end else begin
        wave(int'($urandom_range(8, 13)), int'($urandom_range(6, 12)));
      end
    end
    drive(1'b0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
